mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and block-fill sequencer for the pipelined CPU. It shares one multi-cycle backing memory between the instruction-cache miss path (I) and the data-cache miss/write-through path (D). For reads it issues an 8-word block fill and streams the returned words to the requester. For D writes it issues a single-word write-through. It sits between the cache controllers and the backing memory, and drives the miss-stall handshake the pipeline waits on.

## Interface
Parameters:
- BLOCK_WORDS, 8: words per cache block; fixed at 8 (3-bit word index, 16-byte block).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_req  in  1  I-side fill request; held high until i_done.
- i_addr  in  16  I-side miss byte address.
- d_req  in  1  D-side request; held high until d_done.
- d_wr  in  1  D-side type: 1 = single-word write, 0 = block fill.
- d_addr  in  16  D-side byte address.
- d_wdata  in  16  D-side write data.
- mem_rdata  in  16  read data from the backing memory.
- mem_valid  in  1  mem_rdata valid; read returns arrive in issue order.
- mem_en  out  1  memory access issue strobe.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- fill_data  out  16  returned word; equals mem_rdata.
- fill_word  out  3  index of the returned word within the block.
- i_fill_we  out  1  write fill_data into the I-cache block at fill_word.
- d_fill_we  out  1  write fill_data into the D-cache block at fill_word.
- i_done  out  1  one-cycle pulse: I request complete.
- d_done  out  1  one-cycle pulse: D request complete.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: no access in progress.
  - FILL_I: block fill for the I side.
  - FILL_D: block fill for the D side.
  - WRITE_D: single-word write for the D side.
- Registers:
  - state
  - issue_cnt[3:0]
  - ret_cnt[3:0]
  - base[15:0]
  - last_grant (0 = I, 1 = D)
- Arbitration in IDLE:
  - Only one requester high: grant it.
  - Both high: grant the requester opposite last_grant.
  - last_grant resets to I, so D wins the first tie.
- On grant:
  - last_grant is updated.
  - base = {addr[15:4], 4'h0}.
  - issue_cnt and ret_cnt are cleared.
  - Next state is FILL_I, FILL_D or WRITE_D according to requester and d_wr.
- FILL_x:
  - While issue_cnt < 8: mem_en=1, mem_wr=0, mem_addr = base + {issue_cnt[2:0],1'b0}; issue_cnt increments.
  - Each mem_valid: fill_word = ret_cnt[2:0], x_fill_we = 1, ret_cnt increments.
  - mem_valid with ret_cnt = 7: x_done = 1 that cycle; next state is IDLE.
  - Issue and return may overlap in the same cycle.
- WRITE_D:
  - Lasts exactly one cycle.
  - mem_en=1, mem_wr=1, mem_addr = {d_addr[15:1],1'b0}, mem_wdata = d_wdata.
  - d_done = 1 that cycle; next state is IDLE.
- Idle outputs: mem_en, mem_wr, *_fill_we and *_done are 0 outside the cases above; mem_addr and mem_wdata are 0 when mem_en = 0.
- mem_valid in IDLE or WRITE_D is ignored: no fill_we, no counter change.
- Requesters drop req on the edge that samples done. The arbiter never sees a stale req in the following IDLE cycle.
- Address wrap: base + 14 cannot carry out of the block; 0xFFF0 fills 0xFFF0..0xFFFE.

## Timing
- Reset: rst_n low at a rising edge forces:
  - state = IDLE, counters = 0, last_grant = I.
  - All outputs 0 in the following cycle.
  - Applies mid-fill or mid-write. Partial fills are abandoned and no done is issued.
- The backing memory shares rst_n and discards in-flight reads, so no stale mem_valid follows reset.
- Grant latency: req high in IDLE at edge N gives the first mem_en in cycle N+1.
- Fill issue: 8 consecutive cycles of mem_en (N+1..N+8).
- Fill length: with memory latency L, the last return and x_done fall in cycle N+8+L-1. IDLE is at N+8+L.
- Write: d_done in cycle N+1; IDLE at N+2.
- Back-to-back: a pending opposite request is granted in the IDLE cycle after done. The gap between accesses is one cycle.
- busy = (state != IDLE), combinational from state.

## Test plan
- Single I fill:
  - Stimulus: i_addr=0x123A, memory L=4.
  - Response: mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles; fill_word 0..7 with matching data; i_done once with the word-7 return; busy low afterwards.
- D write:
  - Stimulus: d_wr=1, d_addr=0x0045, d_wdata=0xBEEF.
  - Response: one cycle with mem_en=1, mem_wr=1, addr 0x0044, data 0xBEEF; d_done the same cycle; no fill_we.
- Simultaneous I and D fill requests after reset:
  - Response: D served first, then I after exactly one IDLE cycle.
  - A second D request raised during the I fill is served only after i_done (alternation).
- Reset mid-fill:
  - Stimulus: rst_n low after 3 returns.
  - Response: next cycle all outputs 0, no done; a new I request then fills all 8 words correctly from word 0.
- Spurious mem_valid in IDLE:
  - Response: no fill_we, counters unchanged; a subsequent fill still produces exactly 8 returns.
- Top-of-memory fill:
  - Stimulus: i_addr=0xFFFE.
  - Response: addresses 0xFFF0..0xFFFE with no wrap into 0x0000.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle backing memory between the I-cache fill path and the D-cache
// fill/write-through path; streams 8-word block fills back to the winning requester.
module mem_arbiter #(
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);

  localparam logic [3:0] NumWords = 4'(BLOCK_WORDS);
  localparam logic [3:0] LastWord = 4'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFillI,
    StFillD,
    StWriteD
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  ret_cnt_q, ret_cnt_d;
  logic [15:0] base_q, base_d;
  logic        last_grant_q, last_grant_d;  // 0 = I, 1 = D

  logic        grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      issue_cnt_q  <= 4'd0;
      ret_cnt_q    <= 4'd0;
      base_q       <= 16'h0000;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      base_q       <= base_d;
      last_grant_q <= last_grant_d;
    end
  end

  // On a tie the side that did not win last time gets the memory.
  always_comb begin
    if (i_req && d_req) begin
      grant_d = ~last_grant_q;
    end else begin
      grant_d = d_req;
    end
    grant_i = i_req & ~grant_d;
  end

  assign fill_data = mem_rdata;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    base_d       = base_q;
    last_grant_d = last_grant_q;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    fill_word    = 3'd0;
    i_fill_we    = 1'b0;
    d_fill_we    = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_d) begin
          last_grant_d = 1'b1;
          base_d       = {d_addr[15:4], 4'h0};
          issue_cnt_d  = 4'd0;
          ret_cnt_d    = 4'd0;
          state_d      = d_wr ? StWriteD : StFillD;
        end else if (grant_i) begin
          last_grant_d = 1'b0;
          base_d       = {i_addr[15:4], 4'h0};
          issue_cnt_d  = 4'd0;
          ret_cnt_d    = 4'd0;
          state_d      = StFillI;
        end
      end

      StFillI, StFillD: begin
        if (issue_cnt_q < NumWords) begin
          mem_en      = 1'b1;
          // base is block aligned, so the word offset never carries out of the block
          mem_addr    = base_q + {12'h000, issue_cnt_q[2:0], 1'b0};
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (mem_valid) begin
          fill_word = ret_cnt_q[2:0];
          ret_cnt_d = ret_cnt_q + 4'd1;
          if (state_q == StFillI) begin
            i_fill_we = 1'b1;
          end else begin
            d_fill_we = 1'b1;
          end
          if (ret_cnt_q == LastWord) begin
            state_d = StIdle;
            if (state_q == StFillI) begin
              i_done = 1'b1;
            end else begin
              d_done = 1'b1;
            end
          end
        end
      end

      StWriteD: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {d_addr[15:1], 1'b0};
        mem_wdata = d_wdata;
        d_done    = 1'b1;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus hand-written
// sequences for tie arbitration, reset mid-fill and spurious returns.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we;
  logic        d_fill_we;
  logic        i_done;
  logic        d_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .fill_data (fill_data),
    .fill_word (fill_word),
    .i_fill_we (i_fill_we),
    .d_fill_we (d_fill_we),
    .i_done    (i_done),
    .d_done    (d_done),
    .busy      (busy)
  );

  // Backing memory model, latency 4: a read issued in cycle c returns in cycle c+3.
  logic [2:0]  p_v;
  logic [15:0] p_a [3];
  logic        spur;

  always @(posedge clk) begin
    if (!rst_n) begin
      p_v <= 3'b000;
    end else begin
      p_v    <= {p_v[1:0], mem_en & ~mem_wr};
      p_a[0] <= mem_addr;
      p_a[1] <= p_a[0];
      p_a[2] <= p_a[1];
    end
  end

  assign mem_valid = p_v[2] | spur;
  assign mem_rdata = p_v[2] ? (p_a[2] ^ 16'h5A5A) : (spur ? 16'hDEAD : 16'h0000);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_addr;   // block base for fills, write address for writes
    int          exp_done;   // cycle of done counted from the grant edge
  } txn_t;

  task automatic run_txn(input txn_t t, input string tag);
    int cyc      = 0;
    int issued   = 0;
    int rets     = 0;
    int first_en = 0;
    int done_cyc = 0;
    if (t.is_d) begin
      d_req = 1'b1; d_wr = t.wr; d_addr = t.addr; d_wdata = t.wdata;
    end else begin
      i_req = 1'b1; i_addr = t.addr;
    end
    while (done_cyc == 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_en) begin
        if (first_en == 0) first_en = cyc;
        chk({tag, "_mem_wr"}, mem_wr, t.wr);
        if (t.wr) begin
          chk({tag, "_wr_addr"}, mem_addr, t.exp_addr);
          chk({tag, "_wr_data"}, mem_wdata, t.wdata);
        end else begin
          chk({tag, "_rd_addr"}, mem_addr, t.exp_addr + 16'(2 * issued));
        end
        issued++;
      end else begin
        chk({tag, "_idle_bus"}, {mem_addr, mem_wdata}, 32'h0);
      end
      if (i_fill_we | d_fill_we) begin
        chk({tag, "_fill_side"}, {i_fill_we, d_fill_we}, t.is_d ? 2'b01 : 2'b10);
        chk({tag, "_fill_word"}, fill_word, rets[2:0]);
        chk({tag, "_fill_data"}, fill_data, (t.exp_addr + 16'(2 * rets)) ^ 16'h5A5A);
        rets++;
      end
      if (i_done | d_done) begin
        chk({tag, "_done_side"}, {i_done, d_done}, t.is_d ? 2'b01 : 2'b10);
        done_cyc = cyc;
      end
    end
    if (t.is_d) d_req = 1'b0;
    else i_req = 1'b0;
    d_wr = 1'b0;
    chk({tag, "_first_en_cyc"}, first_en, 1);
    chk({tag, "_done_cyc"}, done_cyc, t.exp_done);
    chk({tag, "_issues"}, issued, t.wr ? 1 : 8);
    chk({tag, "_returns"}, rets, t.wr ? 0 : 8);
    @(posedge clk); #1;
    chk({tag, "_after_idle"}, {busy, mem_en}, 2'b00);
  endtask

  txn_t vecs [6];

  initial begin
    int nd = 0;
    int d_done1 = 0;
    int d_done2 = 0;
    int i_done_c = 0;
    int rets = 0;
    int c = 0;

    vecs[0] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h123A, wdata: 16'h0000, exp_addr: 16'h1230, exp_done: 11};
    vecs[1] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h0045, wdata: 16'hBEEF, exp_addr: 16'h0044, exp_done: 1};
    vecs[2] = '{is_d: 1'b1, wr: 1'b0, addr: 16'h8007, wdata: 16'h0000, exp_addr: 16'h8000, exp_done: 11};
    vecs[3] = '{is_d: 1'b0, wr: 1'b0, addr: 16'hFFFE, wdata: 16'h0000, exp_addr: 16'hFFF0, exp_done: 11};
    vecs[4] = '{is_d: 1'b1, wr: 1'b1, addr: 16'hFFFF, wdata: 16'h1234, exp_addr: 16'hFFFE, exp_done: 1};
    vecs[5] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h0000, wdata: 16'h0000, exp_addr: 16'h0000, exp_done: 11};

    rst_n = 1'b0; i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0; spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, busy}, 7'h0);
    chk("reset_bus", {mem_addr, mem_wdata}, 32'h0);
    rst_n = 1'b1;

    // Tie straight after reset: D wins, I follows after one idle cycle, a new D waits.
    i_req = 1'b1; i_addr = 16'h2000;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h3004;
    for (int k = 1; k <= 37; k++) begin
      @(posedge clk); #1;
      if (k == 1)  chk("tie_first_d", {mem_en, mem_addr}, {1'b1, 16'h3000});
      if (k == 12) chk("tie_gap1", {busy, mem_en}, 2'b00);
      if (k == 13) chk("tie_then_i", {mem_en, mem_addr}, {1'b1, 16'h2000});
      if (k == 24) chk("tie_gap2", {busy, mem_en}, 2'b00);
      if (k == 25) chk("tie_alt_d", {mem_en, mem_addr}, {1'b1, 16'h4000});
      if (k == 37) chk("tie_end_idle", busy, 1'b0);
      if (d_done) begin
        if (nd == 0) d_done1 = k;
        else d_done2 = k;
        nd++;
        d_req = 1'b0;
      end
      if (i_done) begin
        i_done_c = k;
        i_req = 1'b0;
      end
      if (k == 14) begin
        d_req = 1'b1; d_addr = 16'h4000;
      end
    end
    chk("tie_d_done1", d_done1, 11);
    chk("tie_i_done", i_done_c, 23);
    chk("tie_d_done2", d_done2, 35);

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v], $sformatf("vec%0d", v));
    end

    // Reset after three returns abandons the fill without a done.
    i_req = 1'b1; i_addr = 16'h5556;
    rets = 0; c = 0;
    while (rets < 3 && c < 30) begin
      @(posedge clk); #1;
      c++;
      if (i_fill_we) rets++;
      chk("rst_no_early_done", {i_done, d_done}, 2'b00);
    end
    chk("rst_three_returns", rets, 3);
    rst_n = 1'b0; i_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ctrl", {mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, busy}, 7'h0);
    chk("rst_mid_bus", {mem_addr, mem_wdata}, 32'h0);
    chk("rst_mid_fill", {fill_data, 13'(fill_word)}, 29'h0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_quiet", {busy, i_fill_we, i_done}, 3'b000);
    end
    run_txn('{is_d: 1'b0, wr: 1'b0, addr: 16'h5556, wdata: 16'h0, exp_addr: 16'h5550,
              exp_done: 11}, "rst_refill");

    // Spurious returns while idle must be ignored.
    spur = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("spur_no_we", {i_fill_we, d_fill_we, busy}, 3'b000);
      chk("spur_word", fill_word, 3'd0);
    end
    spur = 1'b0;
    run_txn('{is_d: 1'b1, wr: 1'b0, addr: 16'h0A2C, wdata: 16'h0, exp_addr: 16'h0A20,
              exp_done: 11}, "spur_fill");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
